// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and parameter defaults for the pipeline hazard/redirect controller.
// Holds the mult/div timer state codes, next-PC select codes and the default timing/address values.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_EPC = 2'b01;
  localparam logic [1:0] NPC_EXC = 2'b10;

  localparam int          MULT_CYC_DEF  = 5;
  localparam int          DIV_CYC_DEF   = 10;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Occupancy timer for the multiply/divide unit.
// Tracks one operation at a time with a down-counter and exports a registered busy flag.
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_m_req,
  output logic o_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_busy;

  // Starts are only accepted from IDLE; an exception in the same cycle kills the issue.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_m_req) begin
          if (i_is_div) begin
            w_state_nxt = ST_DIV;
            w_cnt_nxt   = DIV_LOAD;
          end else begin
            w_state_nxt = ST_MULT;
            w_cnt_nxt   = MULT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      ST_MULT, ST_DIV: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Busy is registered from the next state so it mirrors (state != IDLE) without a decode glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall, flush and PC-redirect controller.
// Exceptions override everything; eret redirects only once the decode stage is no longer stalled.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MULT_CYC  = MULT_CYC_DEF,
  parameter int          DIV_CYC   = DIV_CYC_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        D_md_use,
  input  logic        D_data_stall,
  input  logic        M_req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  output logic        F_pause,
  output logic        E_flush,
  output logic        all_flush,
  output logic        md_busy,
  output logic [1:0]  npc_sel,
  output logic [31:0] npc_target
);

  logic w_md_busy;
  logic w_md_stall;
  logic w_stall;

  md_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_start  (E_md_start),
    .i_is_div (E_md_is_div),
    .i_m_req  (M_req),
    .o_busy   (w_md_busy)
  );

  assign w_md_stall = D_md_use & (w_md_busy | E_md_start);
  assign w_stall    = (D_data_stall | w_md_stall) & ~M_req;

  assign md_busy   = w_md_busy;
  assign F_pause   = w_stall;
  assign E_flush   = w_stall;
  assign all_flush = M_req;

  // Redirect priority: exception entry, then eret (only when not stalled), else sequential.
  always_comb begin
    npc_sel    = NPC_SEQ;
    npc_target = 32'h0000_0000;
    if (M_req) begin
      npc_sel    = NPC_EXC;
      npc_target = EXC_ENTRY;
    end else if (D_eret && !w_stall) begin
      npc_sel    = NPC_EPC;
      npc_target = EPC;
    end else begin
      npc_sel    = NPC_SEQ;
      npc_target = 32'h0000_0000;
    end
  end

endmodule
